truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

- Synthesizable stimulus/response engine for the small combinational logic blocks in the lab designs (e.g. the 3-input sum-of-products `y = ~a | ~b`).
- Drives every input combination in ascending binary order onto the block under test and samples its single output after a programmable settle time.
- Assembles the observed truth table, compares it with an expected minterm mask, and reports pass/fail with a mismatch count.
- Sits on the input side of the block under test, replacing a hand-written stimulus sequence with on-chip sequential hardware.

## Interface

Parameters:
- `N_IN`, default 3: number of inputs of the block under test; 1..6.
- `SETTLE`, default 1: cycles each vector is held before its response is sampled; ≥1.
- `EXP_MASK`, default `8'h3F` (width `2**N_IN`): expected truth table. Bit i is the expected output for stim == i.

Ports:
- `clk` input 1: single clock; all state on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a sweep; honoured only in IDLE.
- `stim` output `N_IN`: drives the block-under-test inputs; MSB = first input (a), LSB = last (c).
- `resp` input 1: output of the block under test, synchronous to `clk`.
- `busy` output 1: high from the cycle after an accepted `start` through the last sample.
- `done` output 1: one-cycle pulse when the result is valid.
- `table_out` output `2**N_IN`: captured truth table; bit i = `resp` sampled for stim == i.
- `mismatch_cnt` output `N_IN+1`: popcount of `table_out ^ EXP_MASK`.
- `pass` output 1: high when `mismatch_cnt == 0`; valid from `done` onward.

## Operation

- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**
  - `start` = 1 → DRIVE.
  - On that edge: `stim` = 0, settle counter = 0, `table_out` = 0, `mismatch_cnt` = 0.
- **DRIVE**
  - `stim` held constant; settle counter increments each cycle.
  - When the counter reaches `SETTLE-1` → SAMPLE.
- **SAMPLE** (one cycle)
  - `table_out[stim]` ← `resp`.
  - If `resp != EXP_MASK[stim]`, `mismatch_cnt` += 1.
  - If `stim` is all-ones → DONE; otherwise `stim` += 1, counter cleared → DRIVE.
- **DONE** (one cycle): `done` = 1 → IDLE.
- `table_out`, `mismatch_cnt` and `pass` hold their values in IDLE until the next accepted `start`.
- `start` while `busy` is ignored, with no queuing.
- `start` in the DONE cycle is ignored.
- `stim` increments without wrap inside a sweep. The final vector is detected before the increment, so `stim` stays at all-ones through DONE and returns to 0 only on the next `start`.
- `mismatch_cnt` saturates naturally: its maximum is `2**N_IN`, which fits in `N_IN+1` bits.

## Timing

- Reset values (asynchronous on `rst_n` low, including mid-sweep):
  - state = IDLE;
  - `stim`, `busy`, `done`, `table_out`, `mismatch_cnt` = 0;
  - `pass` = 0.
- Reset release needs no warm-up; `start` is accepted on the first edge after release.
- `busy` rises the cycle after `start` and falls in the DONE cycle.
- Each vector occupies `SETTLE+1` cycles: `SETTLE` in DRIVE, 1 in SAMPLE.
- `resp` is sampled `SETTLE` full cycles after `stim` changes.
- `done` is asserted exactly `2**N_IN * (SETTLE+1) + 1` cycles after the `start` edge. Default configuration: 17 cycles.
- `pass` is registered and updates in the same cycle `done` asserts.

## Structure

- Package `sweeper_pkg`:
  - FSM state enum `sweep_state_t`;
  - constant `SETTLE_W = $clog2(SETTLE+1)`.
- The settle counter plus vector counter are natural as one sub-module, `vector_stepper`:
  - inputs: `clk`, `rst_n`, `clear`, `en`;
  - outputs: `stim`, `sample_now`, `last_vec`.
- The top level holds the FSM and the compare/accumulate logic.

## Test plan

1. DUT = `~a | ~b`, default parameters, pulse `start`:
   - `stim` steps 0..7, each held 2 cycles;
   - `table_out` = 8'h3F, `mismatch_cnt` = 0, `pass` = 1;
   - `done` arrives 17 cycles after `start`.
2. `resp` tied to 0 → `table_out` = 8'h00, `mismatch_cnt` = 6, `pass` = 0.
3. `start` pulsed again at cycle 5 of a sweep:
   - ignored; a single `done` at cycle 17;
   - next `start` clears `table_out` before the new sweep.
4. `rst_n` dropped with `stim` = 4 mid-sweep:
   - all outputs 0 immediately (before the next edge), state IDLE;
   - a fresh sweep then completes with `pass` = 1.
5. `SETTLE` = 3, DUT = `a ^ b ^ c`, `EXP_MASK` = 8'h96:
   - each vector held 4 cycles; `done` at cycle 33;
   - `table_out` = 8'h96, `pass` = 1.
6. `N_IN` = 1, inverter DUT, `EXP_MASK` = 2'b01:
   - `done` at cycle 5, `table_out` = 2'b01, `pass` = 1.

Source files
------------

// File: rtl/sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_t;

    localparam int SETTLE_DEF = 1;
    localparam int SETTLE_W   = $clog2(SETTLE_DEF + 1);

    // Counter width able to hold the value SETTLE itself.
    function automatic int settle_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/vector_stepper.sv
// Settle counter plus vector counter: walks stim through 0..2**N_IN-1,
// holding each value for SETTLE drive cycles and one sample cycle.
module vector_stepper
    import sweeper_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            en,
    output logic [N_IN-1:0] stim,
    output logic            sample_now,
    output logic            drive_end,
    output logic            last_vec
);

    localparam int            CW         = settle_width(SETTLE);
    localparam logic [CW-1:0] CNT_DRV_LO = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SETTLE);

    logic [CW-1:0]   r_cnt;
    logic [N_IN-1:0] r_stim;

    assign stim       = r_stim;
    assign sample_now = (r_cnt == CNT_SAMPLE);
    assign drive_end  = (r_cnt == CNT_DRV_LO);
    assign last_vec   = &r_stim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_stim <= '0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_stim <= '0;
        end else if (en) begin
            if (sample_now) begin
                r_cnt <= '0;
                // The final vector is held so stim reads all-ones through DONE.
                if (!last_vec) begin
                    r_stim <= r_stim + N_IN'(1);
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of a small combinational block, captures
// its truth table and compares it against an expected minterm mask.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int                 N_IN     = 3,
    parameter int                 SETTLE   = 1,
    parameter logic [2**N_IN-1:0] EXP_MASK = 8'h3F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [N_IN-1:0]    stim,
    input  logic               resp,
    output logic               busy,
    output logic               done,
    output logic [2**N_IN-1:0] table_out,
    output logic [N_IN:0]      mismatch_cnt,
    output logic               pass
);

    sweep_state_t r_state;
    sweep_state_t w_next;

    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [2**N_IN-1:0] r_table;
    logic [N_IN:0]      r_mis;

    logic [N_IN-1:0] w_stim;
    logic            w_sample_now;
    logic            w_drive_end;
    logic            w_last_vec;
    logic            w_accept;
    logic            w_run;
    logic            w_sample;
    logic            w_miss;
    logic [N_IN:0]   w_mis_next;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_run    = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign w_sample = (r_state == ST_SAMPLE) && w_sample_now;

    vector_stepper #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_stepper (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_accept),
        .en         (w_run),
        .stim       (w_stim),
        .sample_now (w_sample_now),
        .drive_end  (w_drive_end),
        .last_vec   (w_last_vec)
    );

    assign w_miss     = resp ^ EXP_MASK[w_stim];
    assign w_mis_next = r_mis + {{N_IN{1'b0}}, w_miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_DRIVE;
            ST_DRIVE:  if (w_drive_end) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = w_last_vec ? ST_DONE : ST_DRIVE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_table <= '0;
            r_mis   <= '0;
        end else begin
            r_busy <= (w_next == ST_DRIVE) || (w_next == ST_SAMPLE);
            r_done <= (w_next == ST_DONE);
            if (w_accept) begin
                r_table <= '0;
                r_mis   <= '0;
                r_pass  <= 1'b0;
            end else if (w_sample) begin
                r_table[w_stim] <= resp;
                r_mis           <= w_mis_next;
                // Verdict lands together with done, including the last sample.
                if (w_last_vec) begin
                    r_pass <= (w_mis_next == '0);
                end
            end
        end
    end

    assign stim         = w_stim;
    assign busy         = r_busy;
    assign done         = r_done;
    assign table_out    = r_table;
    assign mismatch_cnt = r_mis;
    assign pass         = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed plus randomized checks of truth_table_sweeper against a
// cycle-numbered reference of the sweep and a truth-table model.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic [2:0] s0, s1;
    logic [0:0] s2;
    logic       r0, r1, r2;
    logic       b0, b1, b2, d0, d1, d2, p0, p1, p2;
    logic [7:0] t0, t1;
    logic [1:0] t2;
    logic [3:0] m0, m1;
    logic [1:0] m2;

    int total = 0;
    int bad   = 0;

    // Block-under-test models: output is wrong until the inputs have been
    // stable for the settle time, so early sampling is visible.
    int          mode0 = 1, mode1 = 1, mode2 = 1;
    logic [63:0] tt0 = '0, tt1 = '0, tt2 = '0;
    int          age0 = 1000, age1 = 1000, age2 = 1000;
    logic [2:0]  ps0 = '0, ps1 = '0;
    logic [0:0]  ps2 = '0;

    always @(negedge clk) begin
        age0 <= (s0 !== ps0) ? 0 : ((age0 < 1000) ? age0 + 1 : age0);
        age1 <= (s1 !== ps1) ? 0 : ((age1 < 1000) ? age1 + 1 : age1);
        age2 <= (s2 !== ps2) ? 0 : ((age2 < 1000) ? age2 + 1 : age2);
        ps0  <= s0;
        ps1  <= s1;
        ps2  <= s2;
    end

    assign r0 = (mode0 == 0) ? 1'b0 : ((age0 >= 1) ? tt0[s0] : ~tt0[s0]);
    assign r1 = (mode1 == 0) ? 1'b0 : ((age1 >= 3) ? tt1[s1] : ~tt1[s1]);
    assign r2 = (mode2 == 0) ? 1'b0 : ((age2 >= 1) ? tt2[s2] : ~tt2[s2]);

    truth_table_sweeper u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .stim(s0), .resp(r0),
        .busy(b0), .done(d0), .table_out(t0), .mismatch_cnt(m0), .pass(p0)
    );

    truth_table_sweeper #(
        .N_IN(3), .SETTLE(3), .EXP_MASK(8'h96)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .stim(s1), .resp(r1),
        .busy(b1), .done(d1), .table_out(t1), .mismatch_cnt(m1), .pass(p1)
    );

    truth_table_sweeper #(
        .N_IN(1), .SETTLE(1), .EXP_MASK(2'b01)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .stim(s2), .resp(r2),
        .busy(b2), .done(d2), .table_out(t2), .mismatch_cnt(m2), .pass(p2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic snap(input int inst, output logic [63:0] st,
                        output logic [63:0] tb, output logic [63:0] mc,
                        output logic bz, output logic dn, output logic ps);
        case (inst)
            0: begin
                st = 64'(s0); tb = 64'(t0); mc = 64'(m0);
                bz = b0; dn = d0; ps = p0;
            end
            1: begin
                st = 64'(s1); tb = 64'(t1); mc = 64'(m1);
                bz = b1; dn = d1; ps = p1;
            end
            default: begin
                st = 64'(s2); tb = 64'(t2); mc = 64'(m2);
                bz = b2; dn = d2; ps = p2;
            end
        endcase
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0:       st0 = v;
            1:       st1 = v;
            default: st2 = v;
        endcase
    endtask

    task automatic chk_zero(input int inst, input string tag);
        logic [63:0] st, tb, mc;
        logic        bz, dn, ps;
        snap(inst, st, tb, mc, bz, dn, ps);
        chk({tag, "_stim"}, st, 64'(0));
        chk({tag, "_busy"}, 64'(bz), 64'(0));
        chk({tag, "_done"}, 64'(dn), 64'(0));
        chk({tag, "_table"}, tb, 64'(0));
        chk({tag, "_mis"}, mc, 64'(0));
        chk({tag, "_pass"}, 64'(ps), 64'(0));
    endtask

    // Called just after a negedge. Cycle c is the c-th cycle after the
    // edge that accepts start; done belongs in cycle 2**n*(s+1)+1.
    task automatic sweep(input int inst, input int n, input int s,
                         input logic [63:0] exp_tbl, input logic [63:0] mask,
                         input int extra_start, input int abort_at);
        int          nv, dcyc, ndone;
        logic [63:0] emc, epass;
        logic [63:0] st, tb, mc;
        logic        bz, dn, ps;
        nv    = 1 << n;
        dcyc  = nv * (s + 1) + 1;
        ndone = 0;
        emc   = 64'($countones(exp_tbl ^ mask));
        epass = (emc == 64'(0)) ? 64'(1) : 64'(0);
        set_start(inst, 1'b1);
        @(posedge clk);
        #1 set_start(inst, 1'b0);
        for (int c = 1; c <= dcyc + 2; c++) begin
            @(negedge clk);
            snap(inst, st, tb, mc, bz, dn, ps);
            if (dn) ndone++;
            if (c < dcyc) begin
                chk("busy_run", 64'(bz), 64'(1));
                chk("done_early", 64'(dn), 64'(0));
                chk("stim_step", st, 64'((c - 1) / (s + 1)));
                if (c == 1) begin
                    chk("clr_table", tb, 64'(0));
                    chk("clr_mis", mc, 64'(0));
                    chk("clr_pass", 64'(ps), 64'(0));
                end
            end else if (c == dcyc) begin
                chk("done_cycle", 64'(dn), 64'(1));
                chk("busy_done", 64'(bz), 64'(0));
                chk("stim_last", st, 64'(nv - 1));
                chk("table", tb, exp_tbl);
                chk("mismatch", mc, emc);
                chk("pass", 64'(ps), epass);
            end else begin
                chk("done_single", 64'(dn), 64'(0));
                chk("busy_idle", 64'(bz), 64'(0));
                chk("stim_hold", st, 64'(nv - 1));
                chk("table_hold", tb, exp_tbl);
                chk("mis_hold", mc, emc);
                chk("pass_hold", 64'(ps), epass);
            end
            if (c == abort_at) return;
            set_start(inst, c == extra_start);
        end
        chk("done_count", 64'(ndone), 64'(1));
    endtask

    initial begin
        logic [2:0] v;
        logic [0:0] v1;
        int         dc;
        for (int i = 0; i < 8; i++) begin
            v      = 3'(i);
            tt0[i] = ~v[2] | ~v[1];
            tt1[i] = v[2] ^ v[1] ^ v[0];
        end
        for (int i = 0; i < 2; i++) begin
            v1     = 1'(i);
            tt2[i] = ~v1[0];
        end

        repeat (2) @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(2, "rst2");
        rst_n = 1'b1;

        // Start accepted on the first edge after reset release.
        sweep(0, 3, 1, tt0, 64'h3F, -1, -1);
        // Extra start mid-sweep, then a new start must clear the table.
        sweep(0, 3, 1, tt0, 64'h3F, 5, -1);
        // Start during the DONE cycle is ignored.
        sweep(0, 3, 1, tt0, 64'h3F, 17, -1);

        mode0 = 0;
        sweep(0, 3, 1, 64'h00, 64'h3F, -1, -1);
        mode0 = 1;
        sweep(0, 3, 1, tt0, 64'h3F, -1, -1);

        // Asynchronous reset in the cycle stim reads 4.
        sweep(0, 3, 1, tt0, 64'h3F, -1, 9);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 3, 1, tt0, 64'h3F, -1, -1);

        sweep(1, 3, 3, tt1, 64'h96, -1, -1);
        sweep(2, 1, 1, tt2, 64'h1, -1, -1);

        for (int k = 0; k < 4; k++) begin
            tt0 = 64'($urandom_range(0, 255));
            dc  = 8 * 2 + 1;
            sweep(0, 3, 1, tt0, 64'h3F, int'($urandom_range(1, dc)), -1);
            tt1 = 64'($urandom_range(0, 255));
            dc  = 8 * 4 + 1;
            sweep(1, 3, 3, tt1, 64'h96, int'($urandom_range(1, dc)), -1);
            tt2 = 64'($urandom_range(0, 3));
            sweep(2, 1, 1, tt2, 64'h1, int'($urandom_range(1, 5)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
